// File: rtl/fb_port_arbiter_if.sv
// Frame-buffer port arbiter bus bundle.
// Groups the camera write port, VGA timing/pixel port and the single-port RAM
// port of fb_port_arbiter. Clock and reset are not part of the bundle.
//   slave  : arbiter side (drives cam_full, mem_*, pix_data, overflow)
//   master : environment side (drives mode selects, VGA timing, camera, mem_rdata)
interface fb_port_arbiter_if #(
  parameter int unsigned AW = 19,
  parameter int unsigned DW = 12
) ();

  // Mode select and VGA timing
  logic          rez_160x120;
  logic          rez_320x240;
  logic          activeArea;
  logic          Vsync;

  // Camera write port
  logic          cam_we;
  logic [AW-1:0] cam_addr;
  logic [DW-1:0] cam_data;
  logic          cam_full;

  // Single-port RAM
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  // Pixel output and status
  logic [DW-1:0] pix_data;
  logic          overflow;

  modport slave (
    input  rez_160x120, rez_320x240, activeArea, Vsync,
    input  cam_we, cam_addr, cam_data, mem_rdata,
    output cam_full, mem_addr, mem_wdata, mem_we, pix_data, overflow
  );

  modport master (
    output rez_160x120, rez_320x240, activeArea, Vsync,
    output cam_we, cam_addr, cam_data, mem_rdata,
    input  cam_full, mem_addr, mem_wdata, mem_we, pix_data, overflow
  );

endinterface

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter.
// Shares one single-port synchronous RAM between the VGA reader (absolute
// priority while activeArea=1) and a camera writer buffered by a small FIFO
// that drains during blanking.
// Ports:
//   CLK25  : pixel clock, only clock of the block
//   Nreset : asynchronous active-low reset
//   bus    : fb_port_arbiter_if.slave (mode, VGA timing, camera, RAM, pixel out)
module fb_port_arbiter #(
  parameter int unsigned AW    = 19,
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic              CLK25,
  input  logic              Nreset,
  fb_port_arbiter_if.slave  bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] LAST_160 = AW'(19200 - 1);
  localparam logic [AW-1:0] LAST_320 = AW'(76800 - 1);
  localparam logic [AW-1:0] LAST_640 = AW'(307200 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e        state_q, state_d;

  // FIFO storage and bookkeeping
  logic [AW-1:0] fifo_addr_q [DEPTH];
  logic [DW-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          vsync_q;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] pix_data_q, pix_data_d;
  logic          cam_full_q, cam_full_d;
  logic          overflow_q, overflow_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          drop;
  logic          vsync_fall;
  logic [AW-1:0] frame_last;

  // Status decode from current registered state
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    push       = bus.cam_we & ~fifo_full;
    drop       = bus.cam_we & fifo_full;
    vsync_fall = vsync_q & ~bus.Vsync;
    if (bus.rez_160x120) begin
      frame_last = LAST_160;
    end else if (bus.rez_320x240) begin
      frame_last = LAST_320;
    end else begin
      frame_last = LAST_640;
    end
  end

  // Grant decision, RAM port drive, read address and FIFO next state
  always_comb begin
    state_d     = ST_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    pop         = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (bus.activeArea) begin
      state_d = ST_READ;
    end else if (!fifo_empty) begin
      state_d = ST_WRITE;
    end

    case (state_d)
      ST_READ: begin
        mem_addr_d = rd_addr_q;
        // >= so a mid-frame switch to a smaller mode still wraps
        rd_addr_d  = (rd_addr_q >= frame_last) ? '0 : rd_addr_q + AW'(1);
      end
      ST_WRITE: begin
        pop         = 1'b1;
        mem_addr_d  = fifo_addr_q[rd_ptr_q];
        mem_wdata_d = fifo_data_q[rd_ptr_q];
        mem_we_d    = 1'b1;
      end
      default: ;
    endcase

    // Frame start wins over any increment this cycle
    if (vsync_fall) begin
      rd_addr_d = '0;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pixel pipeline: rvalid marks that mem_addr currently carries a read,
  // so mem_rdata one cycle later belongs to a READ slot.
  always_comb begin
    rvalid_d   = (state_q == ST_READ);
    pix_data_d = rvalid_q ? bus.mem_rdata : '0;
    cam_full_d = (count_d == FULL_CNT);
    overflow_d = overflow_q | drop;
  end

  // State and control registers
  always_ff @(posedge CLK25 or negedge Nreset) begin
    if (!Nreset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_addr_q   <= '0;
      vsync_q     <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      pix_data_q  <= '0;
      cam_full_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_addr_q   <= rd_addr_d;
      vsync_q     <= bus.Vsync;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rvalid_q    <= rvalid_d;
      pix_data_q  <= pix_data_d;
      cam_full_q  <= cam_full_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge CLK25) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.cam_addr;
      fifo_data_q[wr_ptr_q] <= bus.cam_data;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.cam_full  = cam_full_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter (default parameters).
module tb_fb_port_arbiter;

  logic clk = 1'b0;
  logic nreset;
  int   checks = 0;
  int   errors = 0;

  fb_port_arbiter_if #(.AW(19), .DW(12)) bus ();

  fb_port_arbiter #(.AW(19), .DW(12), .DEPTH(4)) dut (
    .CLK25  (clk),
    .Nreset (nreset),
    .bus    (bus)
  );

  always #20 clk = ~clk;

  // RAM model: synchronous read returning the address as data
  always @(posedge clk) bus.mem_rdata <= 12'(bus.mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    nreset              = 1'b0;
    bus.rez_160x120     = 1'b0;
    bus.rez_320x240     = 1'b0;
    bus.activeArea      = 1'b0;
    bus.Vsync           = 1'b1;
    bus.cam_we          = 1'b0;
    bus.cam_addr        = '0;
    bus.cam_data        = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_addr",  32'(bus.mem_addr),  0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_we",    32'(bus.mem_we),    0);
    chk("rst_pix",   32'(bus.pix_data),  0);
    chk("rst_full",  32'(bus.cam_full),  0);
    chk("rst_ovf",   32'(bus.overflow),  0);
    nreset = 1'b1;

    // Three camera writes during blanking drain back-to-back in order
    bus.cam_we = 1'b1; bus.cam_addr = 19'd10; bus.cam_data = 12'h111;
    tick();
    chk("w3_we0", 32'(bus.mem_we), 0);
    bus.cam_addr = 19'd20; bus.cam_data = 12'h222;
    tick();
    chk("w3_we1", 32'(bus.mem_we), 1);
    chk("w3_a1",  32'(bus.mem_addr), 10);
    chk("w3_d1",  32'(bus.mem_wdata), 32'h111);
    bus.cam_addr = 19'd30; bus.cam_data = 12'h333;
    tick();
    chk("w3_we2", 32'(bus.mem_we), 1);
    chk("w3_a2",  32'(bus.mem_addr), 20);
    chk("w3_d2",  32'(bus.mem_wdata), 32'h222);
    bus.cam_we = 1'b0;
    tick();
    chk("w3_we3", 32'(bus.mem_we), 1);
    chk("w3_a3",  32'(bus.mem_addr), 30);
    chk("w3_d3",  32'(bus.mem_wdata), 32'h333);
    tick();
    chk("w3_idle_we",   32'(bus.mem_we), 0);
    chk("w3_idle_hold", 32'(bus.mem_addr), 30);

    // Camera burst during active video: fill, drop, overflow, then drain
    bus.activeArea = 1'b1;
    bus.cam_we     = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus.cam_addr = 19'(100 + i);
      bus.cam_data = 12'(32'hA0 + i);
      tick();
      cnt += int'(bus.mem_we);
      if (i == 2) chk("burst_full_lo", 32'(bus.cam_full), 0);
      if (i == 3) begin
        chk("burst_full_hi", 32'(bus.cam_full), 1);
        chk("burst_ovf_lo",  32'(bus.overflow), 0);
      end
      if (i == 4) chk("burst_ovf_hi", 32'(bus.overflow), 1);
    end
    chk("burst_no_we", 32'(cnt), 0);
    bus.activeArea = 1'b0;
    bus.cam_we     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_we",   32'(bus.mem_we), 1);
      chk("drain_addr", 32'(bus.mem_addr), 32'(100 + i));
      chk("drain_data", 32'(bus.mem_wdata), 32'hA0 + 32'(i));
      if (i == 0) chk("drain_full", 32'(bus.cam_full), 0);
    end
    tick();
    chk("drain_done", 32'(bus.mem_we), 0);
    chk("ovf_sticky", 32'(bus.overflow), 1);

    // Vsync clear during blanking and coinciding with a read; pixel pipeline
    bus.Vsync = 1'b0;
    tick();
    bus.Vsync = 1'b1;
    bus.activeArea = 1'b1;
    repeat (500) tick();
    chk("rd_499", 32'(bus.mem_addr), 499);
    bus.activeArea = 1'b0;
    bus.Vsync = 1'b0;
    tick();
    bus.Vsync = 1'b1;
    bus.activeArea = 1'b1;
    tick();
    chk("vs_clr", 32'(bus.mem_addr), 0);
    tick();                      // issues 1
    tick();                      // issues 2
    bus.Vsync = 1'b0;
    tick();                      // issues 3, clears rd_addr
    chk("vs_coinc_addr", 32'(bus.mem_addr), 3);
    bus.Vsync = 1'b1;
    tick();
    chk("vs_coinc_next", 32'(bus.mem_addr), 0);
    chk("pix_a2", 32'(bus.pix_data), 2);
    tick();                      // issues 1
    chk("pix_a3", 32'(bus.pix_data), 3);
    tick();                      // issues 2
    chk("pix_a0", 32'(bus.pix_data), 0);
    bus.activeArea = 1'b0;
    tick();
    chk("pix_a1", 32'(bus.pix_data), 1);
    chk("blank_hold", 32'(bus.mem_addr), 2);
    tick();
    chk("pix_a2b", 32'(bus.pix_data), 2);
    tick();
    chk("pix_blank", 32'(bus.pix_data), 0);

    // Full 160x120 frame of reads, then wrap
    bus.Vsync = 1'b0;
    tick();
    bus.Vsync = 1'b1;
    bus.rez_160x120 = 1'b1;
    bus.activeArea  = 1'b1;
    cnt = 0;
    for (int k = 0; k < 19200; k++) begin
      tick();
      if (bus.mem_addr !== 19'(k)) cnt++;
    end
    chk("seq160_errs", 32'(cnt), 0);
    chk("seq160_last", 32'(bus.mem_addr), 19199);
    tick();
    chk("wrap160", 32'(bus.mem_addr), 0);
    bus.activeArea  = 1'b0;
    bus.rez_160x120 = 1'b0;

    // Reset mid-operation with two FIFO entries pending
    bus.activeArea = 1'b1;
    bus.cam_we = 1'b1; bus.cam_addr = 19'd7; bus.cam_data = 12'h077;
    tick();
    bus.cam_addr = 19'd8; bus.cam_data = 12'h088;
    tick();
    bus.cam_we = 1'b0;
    bus.activeArea = 1'b0;
    #5;
    nreset = 1'b0;
    #1;
    chk("mr_addr",  32'(bus.mem_addr),  0);
    chk("mr_wdata", 32'(bus.mem_wdata), 0);
    chk("mr_we",    32'(bus.mem_we),    0);
    chk("mr_pix",   32'(bus.pix_data),  0);
    chk("mr_full",  32'(bus.cam_full),  0);
    chk("mr_ovf",   32'(bus.overflow),  0);
    repeat (2) tick();
    nreset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt += int'(bus.mem_we);
    end
    chk("mr_no_write", 32'(cnt), 0);
    chk("mr_addr_hold", 32'(bus.mem_addr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
